y_expr_structural: RTL and testbench

- Gate-level (structural) implementation of the four-input Boolean function Y = (A·B) + (C·D').
- Provides a combinational tap and a registered output.
- Used as the reference logic block for the Y-expression lab datapath.
- The registered output feeds synchronous downstream logic.
- The combinational tap is for direct observation and truth-table checking.

---
 rtl/y_expr_structural.sv | 34 +++
 tb/tb_y_expr_structural.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/y_expr_structural.sv
// Gate-level Y = (A.B) + (C.D') with a combinational tap
// and a registered copy of the result.
module y_expr_structural #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y_comb,
    output logic y
);

    logic nd;
    logic p0;
    logic p1;

    not u_not_d  (nd, d);
    and u_and_ab (p0, a, b);
    and u_and_cd (p1, c, nd);
    or  u_or_y   (y_comb, p0, p1);

    // Reset acts without a clock edge; y_comb is never gated by it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= RESET_VALUE;
        end else begin
            y <= y_comb;
        end
    end

endmodule

// File: tb/tb_y_expr_structural.sv
// Bench for y_expr_structural: vector table for the tap,
// scoreboard queue for the registered output.
module tb_y_expr_structural;

    logic clk;
    logic rst_n;
    logic a;
    logic b;
    logic c;
    logic d;
    logic y_comb;
    logic y;

    typedef struct {
        logic [3:0] abcd;
        logic       exp;
    } vec_t;

    vec_t   tbl[$];
    logic   sb[$];
    logic   last_y;
    logic [15:0] mask;
    int     checks;
    int     errors;

    y_expr_structural #(.RESET_VALUE(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .y_comb(y_comb),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act,
                       input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive a vector between edges, check the tap and that y holds,
    // then compare y after the next edge against the scoreboard.
    task automatic apply(input vec_t v, input string tag);
        logic e;
        @(negedge clk);
        {a, b, c, d} = v.abcd;
        #1;
        chk({tag, "_comb"}, y_comb, v.exp);
        chk({tag, "_hold"}, y, last_y);
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "_reg"}, y, e);
        last_y = e;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mask   = 16'hF444;

        tbl.push_back('{4'b0000, 1'b0});
        tbl.push_back('{4'b0111, 1'b0});
        tbl.push_back('{4'b1010, 1'b1});
        tbl.push_back('{4'b1101, 1'b1});
        tbl.push_back('{4'b1110, 1'b1});
        tbl.push_back('{4'b0010, 1'b1});
        for (int i = 0; i < 16; i++) begin
            tbl.push_back('{i[3:0], mask[i]});
        end

        rst_n = 1'b1;
        {a, b, c, d} = 4'b1101;
        @(posedge clk);
        #1;
        chk("pre_reset_y", y, 1'b1);

        // Reset asserted between edges clears y at once.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_y_immediate", y, 1'b0);
        chk("rst_y_comb", y_comb, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_y_held", y, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_y_before_edge", y, 1'b0);
        @(posedge clk);
        #1;
        chk("rel_y_first_edge", y, 1'b1);
        last_y = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("vec%0d_%b", i, tbl[i].abcd));
        end

        // Mid-operation reset while y=1.
        apply('{4'b1100, 1'b1}, "mid_set");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_y", y, 1'b0);
        chk("mid_rst_comb", y_comb, 1'b1);
        @(posedge clk);
        #1;
        chk("mid_rst_y_held", y, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_y", y, 1'b1);
        last_y = 1'b1;

        // Toggle d alone with c=1 and a.b=0.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                apply('{4'b0010, 1'b1}, $sformatf("dtog%0d", k));
            end else begin
                apply('{4'b0011, 1'b0}, $sformatf("dtog%0d", k));
            end
        end

        chk("sb_empty", sb.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
